de_skid_calcpc: RTL and testbench

//  Parametrised decode->execute stage for the branch/jump target-calculation path.

---
 rtl/de_skid_calcpc_pkg.sv | 17 +
 rtl/de_skid_calcpc_if.sv | 47 ++++
 rtl/de_skid_calcpc_slot.sv | 33 +++
 rtl/de_skid_calcpc.sv | 170 +++++++++++++++++
 tb/tb_de_skid_calcpc.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/de_skid_calcpc_pkg.sv
// Shared constants and FSM state type for the decode->execute target-calc stage.
package de_skid_calcpc_pkg;

    localparam int unsigned JUMP_W   = 2;
    localparam int unsigned BRANCH_W = 3;

    localparam logic [JUMP_W-1:0]   JUMP_NONE   = 2'b00;
    localparam logic [BRANCH_W-1:0] BRANCH_NONE = 3'b000;

    // Occupancy of the 2-entry skid variant.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b01,
        StFull  = 2'b10
    } state_e;

endpackage

// File: rtl/de_skid_calcpc_if.sv
// Decode->execute handshake bus: valid/ready plus the branch-calc payload.
interface de_skid_calcpc_if
    import de_skid_calcpc_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 13,
    parameter int unsigned IMM_W = 13,
    parameter int unsigned BN_W  = 2
) ();

    logic                in_valid;
    logic                in_ready;
    logic [BN_W-1:0]     in_bn;
    logic [PC_W-1:0]     in_pc;
    logic [XLEN-1:0]     in_rs1;
    logic [XLEN-1:0]     in_rs2;
    logic [IMM_W-1:0]    in_imm;
    logic [JUMP_W-1:0]   in_jump;
    logic [BRANCH_W-1:0] in_branch;

    logic                out_valid;
    logic                out_ready;
    logic [BN_W-1:0]     out_bn;
    logic [PC_W-1:0]     out_pc;
    logic [XLEN-1:0]     out_rs1;
    logic [XLEN-1:0]     out_rs2;
    logic [IMM_W-1:0]    out_imm;
    logic [JUMP_W-1:0]   out_jump;
    logic [BRANCH_W-1:0] out_branch;

    // Environment side: drives decode entries and the execute-side ready.
    modport master (
        output in_valid, in_bn, in_pc, in_rs1, in_rs2, in_imm, in_jump, in_branch,
        input  in_ready,
        input  out_valid, out_bn, out_pc, out_rs1, out_rs2, out_imm, out_jump, out_branch,
        output out_ready
    );

    // Stage side.
    modport slave (
        input  in_valid, in_bn, in_pc, in_rs1, in_rs2, in_imm, in_jump, in_branch,
        output in_ready,
        output out_valid, out_bn, out_pc, out_rs1, out_rs2, out_imm, out_jump, out_branch,
        input  out_ready
    );

endinterface

// File: rtl/de_skid_calcpc_slot.sv
// One payload register with a valid bit, load enable and synchronous clear.
module de_skid_calcpc_slot #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    logic         valid_q;
    logic [W-1:0] data_q;

    // Clear drops only the valid bit; payload holds its last value as a don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr) begin
            valid_q <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= din;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/de_skid_calcpc.sv
// Decode->execute stage for the branch/jump target path with valid/ready handshake.
// SKID=1 adds a second slot so in_ready can come straight from a flop.
module de_skid_calcpc
    import de_skid_calcpc_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned PC_W  = 13,
    parameter int unsigned IMM_W = 13,
    parameter int unsigned BN_W  = 2,
    parameter int unsigned SKID  = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            flush,
    de_skid_calcpc_if.slave bus
);

    typedef struct packed {
        logic [BN_W-1:0]     bn;
        logic [PC_W-1:0]     pc;
        logic [XLEN-1:0]     rs1;
        logic [XLEN-1:0]     rs2;
        logic [IMM_W-1:0]    imm;
        logic [JUMP_W-1:0]   jump;
        logic [BRANCH_W-1:0] branch;
    } payload_t;

    localparam int unsigned PAY_W = $bits(payload_t);

    payload_t in_pay;
    payload_t main_din;
    payload_t main_dout;
    logic     main_valid;
    logic     main_load;
    logic     main_clr;
    logic     in_ready;
    logic     fire_in;
    logic     fire_out;

    assign in_pay = '{
        bn:     bus.in_bn,
        pc:     bus.in_pc,
        rs1:    bus.in_rs1,
        rs2:    bus.in_rs2,
        imm:    bus.in_imm,
        jump:   bus.in_jump,
        branch: bus.in_branch
    };

    // An entry offered during flush is dropped even if in_ready is high.
    assign fire_in  = bus.in_valid & in_ready & ~flush;
    assign fire_out = main_valid & bus.out_ready;

    de_skid_calcpc_slot #(
        .W (PAY_W)
    ) u_main (
        .clk   (CLK),
        .rst   (RST),
        .clr   (main_clr),
        .load  (main_load),
        .din   (main_din),
        .valid (main_valid),
        .dout  (main_dout)
    );

    if (SKID != 0) begin : g_skid
        state_e   state_q;
        state_e   state_d;
        logic     ready_q;
        logic     skid_load;
        logic     skid_clr;
        logic     skid_valid;
        payload_t skid_dout;

        de_skid_calcpc_slot #(
            .W (PAY_W)
        ) u_skid (
            .clk   (CLK),
            .rst   (RST),
            .clr   (skid_clr),
            .load  (skid_load),
            .din   (in_pay),
            .valid (skid_valid),
            .dout  (skid_dout)
        );

        // Next-state and slot control; flush overrides any handshake.
        always_comb begin
            state_d   = state_q;
            main_din  = in_pay;
            main_load = 1'b0;
            main_clr  = 1'b0;
            skid_load = 1'b0;
            skid_clr  = 1'b0;
            if (flush) begin
                state_d  = StEmpty;
                main_clr = 1'b1;
                skid_clr = 1'b1;
            end else begin
                unique case (state_q)
                    StEmpty: begin
                        if (fire_in) begin
                            main_load = 1'b1;
                            state_d   = StOne;
                        end
                    end
                    StOne: begin
                        if (fire_in && fire_out) begin
                            main_load = 1'b1;
                        end else if (fire_in) begin
                            skid_load = 1'b1;
                            state_d   = StFull;
                        end else if (fire_out) begin
                            main_clr = 1'b1;
                            state_d  = StEmpty;
                        end
                    end
                    StFull: begin
                        // Skid entry moves up behind the consumed head.
                        if (fire_out) begin
                            main_din  = skid_dout;
                            main_load = skid_valid;
                            skid_clr  = 1'b1;
                            state_d   = StOne;
                        end
                    end
                    default: begin
                        state_d  = StEmpty;
                        main_clr = 1'b1;
                        skid_clr = 1'b1;
                    end
                endcase
            end
        end

        // State register; in_ready is a flopped copy of "not full next cycle".
        always_ff @(posedge CLK) begin
            if (RST) begin
                state_q <= StEmpty;
                ready_q <= 1'b1;
            end else begin
                state_q <= state_d;
                ready_q <= (state_d != StFull);
            end
        end

        assign in_ready = ready_q;
    end else begin : g_noskid
        // Single slot: accept when empty or when the head leaves this cycle.
        always_comb begin
            main_din  = in_pay;
            main_load = fire_in;
            main_clr  = flush | (fire_out & ~fire_in);
        end

        assign in_ready = ~main_valid | bus.out_ready;
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = main_valid;
    assign bus.out_bn     = main_dout.bn;
    assign bus.out_pc     = main_dout.pc;
    assign bus.out_rs1    = main_dout.rs1;
    assign bus.out_rs2    = main_dout.rs2;
    assign bus.out_imm    = main_dout.imm;
    // Bubbles must never look like a jump/branch to execute.
    assign bus.out_jump   = main_valid ? main_dout.jump : JUMP_NONE;
    assign bus.out_branch = main_valid ? main_dout.branch : BRANCH_NONE;

endmodule

// File: tb/tb_de_skid_calcpc.sv
// Bench for de_skid_calcpc: SKID=1, SKID=0 and a wide-parameter instance.
module tb_de_skid_calcpc;

    typedef struct packed {
        logic [1:0]  bn;
        logic [12:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [12:0] imm;
        logic [1:0]  jump;
        logic [2:0]  branch;
    } ent_t;

    logic clk;
    logic rst;
    logic flush;
    logic flush_w;

    int n_checks;
    int n_fail;

    // Reference: per DUT an ordered list of held entries (index 0 = skid, 1 = no-skid).
    ent_t mdl [2][2];
    int   cnt [2];

    logic cur_iv;
    logic cur_ordy;
    logic cur_fl;
    ent_t cur_e;

    de_skid_calcpc_if #(.XLEN(32), .PC_W(13), .IMM_W(13), .BN_W(2)) if_s ();
    de_skid_calcpc_if #(.XLEN(32), .PC_W(13), .IMM_W(13), .BN_W(2)) if_n ();
    de_skid_calcpc_if #(.XLEN(64), .PC_W(32), .IMM_W(13), .BN_W(3)) if_w ();

    de_skid_calcpc #(.XLEN(32), .PC_W(13), .IMM_W(13), .BN_W(2), .SKID(1)) u_s (
        .CLK   (clk),
        .RST   (rst),
        .flush (flush),
        .bus   (if_s)
    );

    de_skid_calcpc #(.XLEN(32), .PC_W(13), .IMM_W(13), .BN_W(2), .SKID(0)) u_n (
        .CLK   (clk),
        .RST   (rst),
        .flush (flush),
        .bus   (if_n)
    );

    de_skid_calcpc #(.XLEN(64), .PC_W(32), .IMM_W(13), .BN_W(3), .SKID(1)) u_w (
        .CLK   (clk),
        .RST   (rst),
        .flush (flush_w),
        .bus   (if_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t rnd_ent();
        ent_t e;
        e.bn     = 2'($urandom);
        e.pc     = 13'($urandom);
        e.rs1    = $urandom;
        e.rs2    = $urandom;
        e.imm    = 13'($urandom);
        e.jump   = 2'($urandom);
        e.branch = 3'($urandom);
        return e;
    endfunction

    function automatic ent_t mk(input logic [12:0] pc);
        ent_t e;
        e        = rnd_ent();
        e.pc     = pc;
        e.jump   = 2'b10;
        e.branch = 3'b011;
        return e;
    endfunction

    task automatic drive(input logic iv, input logic ordy, input logic fl, input ent_t e);
        cur_iv   = iv;
        cur_ordy = ordy;
        cur_fl   = fl;
        cur_e    = e;
        flush    = fl;
        if_s.in_valid = iv;  if_s.out_ready = ordy;
        if_s.in_bn = e.bn;   if_s.in_pc = e.pc;   if_s.in_rs1 = e.rs1;  if_s.in_rs2 = e.rs2;
        if_s.in_imm = e.imm; if_s.in_jump = e.jump; if_s.in_branch = e.branch;
        if_n.in_valid = iv;  if_n.out_ready = ordy;
        if_n.in_bn = e.bn;   if_n.in_pc = e.pc;   if_n.in_rs1 = e.rs1;  if_n.in_rs2 = e.rs2;
        if_n.in_imm = e.imm; if_n.in_jump = e.jump; if_n.in_branch = e.branch;
    endtask

    // Compare one DUT with its reference list, then apply this cycle's transfers.
    task automatic check_side(input int d);
        string nm;
        logic  rdy;
        logic  ov;
        ent_t  o;
        logic  exp_rdy;
        logic  fire_in;
        logic  fire_out;
        if (d == 0) begin
            nm = "skid";
            rdy = if_s.in_ready; ov = if_s.out_valid;
            o.bn = if_s.out_bn; o.pc = if_s.out_pc; o.rs1 = if_s.out_rs1; o.rs2 = if_s.out_rs2;
            o.imm = if_s.out_imm; o.jump = if_s.out_jump; o.branch = if_s.out_branch;
            exp_rdy = (cnt[0] < 2);
        end else begin
            nm = "noskid";
            rdy = if_n.in_ready; ov = if_n.out_valid;
            o.bn = if_n.out_bn; o.pc = if_n.out_pc; o.rs1 = if_n.out_rs1; o.rs2 = if_n.out_rs2;
            o.imm = if_n.out_imm; o.jump = if_n.out_jump; o.branch = if_n.out_branch;
            exp_rdy = (cnt[1] == 0) || cur_ordy;
        end
        check({nm, " in_ready"}, 64'(rdy), 64'(exp_rdy));
        check({nm, " out_valid"}, 64'(ov), 64'(cnt[d] > 0));
        if (cnt[d] > 0) begin
            check({nm, " out_pc"}, 64'(o.pc), 64'(mdl[d][0].pc));
            check({nm, " out_rs1"}, 64'(o.rs1), 64'(mdl[d][0].rs1));
            check({nm, " out_rs2"}, 64'(o.rs2), 64'(mdl[d][0].rs2));
            check({nm, " bn/imm/jump/branch"}, 64'({o.bn, o.imm, o.jump, o.branch}),
                  64'({mdl[d][0].bn, mdl[d][0].imm, mdl[d][0].jump, mdl[d][0].branch}));
        end else begin
            check({nm, " bubble jump/branch"}, 64'({o.jump, o.branch}), 64'(0));
        end
        fire_in  = cur_iv && exp_rdy && !cur_fl;
        fire_out = (cnt[d] > 0) && cur_ordy;
        if (cur_fl) begin
            cnt[d] = 0;
        end else begin
            if (fire_out) begin
                mdl[d][0] = mdl[d][1];
                cnt[d]--;
            end
            if (fire_in) begin
                mdl[d][cnt[d]] = cur_e;
                cnt[d]++;
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        check_side(0);
        check_side(1);
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cnt[0]   = 0;
        cnt[1]   = 0;
        flush_w  = 1'b0;
        rst      = 1'b1;
        drive(1'b0, 1'b0, 1'b0, mk(13'h0));
        if_w.in_valid = 1'b0; if_w.out_ready = 1'b1;
        if_w.in_bn = '0; if_w.in_pc = '0; if_w.in_rs1 = '0; if_w.in_rs2 = '0;
        if_w.in_imm = '0; if_w.in_jump = '0; if_w.in_branch = '0;

        // Reset held for two cycles.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        settle();
        check("rst skid out_valid", 64'(if_s.out_valid), 64'(0));
        check("rst skid jump/branch", 64'({if_s.out_jump, if_s.out_branch}), 64'(0));
        check("rst skid in_ready", 64'(if_s.in_ready), 64'(1));
        check("rst noskid out_valid", 64'(if_n.out_valid), 64'(0));
        check("rst noskid in_ready", 64'(if_n.in_ready), 64'(1));
        check("rst wide out_valid", 64'(if_w.out_valid), 64'(0));
        check("rst wide jump/branch", 64'({if_w.out_jump, if_w.out_branch}), 64'(0));
        check("rst wide in_ready", 64'(if_w.in_ready), 64'(1));
        advance();

        // Back-to-back stream with execute always ready.
        drive(1'b1, 1'b1, 1'b0, mk(13'h004)); cycle();
        drive(1'b1, 1'b1, 1'b0, mk(13'h008)); cycle();
        drive(1'b1, 1'b1, 1'b0, mk(13'h00C)); cycle();
        drive(1'b0, 1'b1, 1'b0, mk(13'h000)); cycle();
        cycle();

        // Stall: A lands, B arrives while execute is blocked.
        drive(1'b1, 1'b1, 1'b0, mk(13'h010)); cycle();
        drive(1'b1, 1'b0, 1'b0, mk(13'h014)); cycle();
        drive(1'b0, 1'b0, 1'b0, mk(13'h000));
        settle();
        check("stall skid in_ready", 64'(if_s.in_ready), 64'(0));
        check("stall skid head pc", 64'(if_s.out_pc), 64'(13'h010));
        advance();
        drive(1'b0, 1'b1, 1'b0, mk(13'h000));
        repeat (3) cycle();

        // Refill to full, then flush with C offered.
        drive(1'b1, 1'b0, 1'b0, mk(13'h020)); cycle();
        drive(1'b1, 1'b0, 1'b0, mk(13'h024)); cycle();
        drive(1'b1, 1'b0, 1'b1, mk(13'h0C0)); cycle();
        drive(1'b0, 1'b1, 1'b0, mk(13'h000));
        settle();
        check("flush skid out_valid", 64'(if_s.out_valid), 64'(0));
        check("flush skid jump/branch", 64'({if_s.out_jump, if_s.out_branch}), 64'(0));
        check("flush skid in_ready", 64'(if_s.in_ready), 64'(1));
        advance();
        repeat (3) cycle();

        // Random traffic; second half favours a ready execute stage.
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < ((i < 5000) ? 4 : 8),
                  $urandom_range(0, 31) == 0,
                  rnd_ent());
            cycle();
        end
        drive(1'b0, 1'b1, 1'b0, mk(13'h000));
        cycle();

        // Wide instance passes payload bits unchanged.
        check("wide in_ready", 64'(if_w.in_ready), 64'(1));
        if_w.in_valid  = 1'b1;
        if_w.in_rs1    = 64'hFFFF_FFFF_0000_0001;
        if_w.in_bn     = 3'b101;
        if_w.in_pc     = 32'h1234_5678;
        if_w.in_jump   = 2'b01;
        if_w.in_branch = 3'b110;
        @(posedge clk);
        #1;
        if_w.in_valid = 1'b0;
        settle();
        check("wide out_valid", 64'(if_w.out_valid), 64'(1));
        check("wide out_rs1", if_w.out_rs1, 64'hFFFF_FFFF_0000_0001);
        check("wide out_bn", 64'(if_w.out_bn), 64'(3'b101));
        check("wide out_pc", 64'(if_w.out_pc), 64'(32'h1234_5678));
        check("wide jump/branch", 64'({if_w.out_jump, if_w.out_branch}), 64'(5'b01110));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
